vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_sync_edge.sv | 30 +++
 rtl/vga_capture.sv | 172 +++++++++++++++++
 tb/tb_vga_capture.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : 1280x1024 VGA timing constants and capture FSM state encoding,
//             shared between the capture block and the VGA generator.
//  Revision : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

   // Horizontal timing in pixel strobes
   localparam int HD     = 1280;
   localparam int HF     = 48;
   localparam int HR     = 112;
   localparam int HB     = 248;
   localparam int HTOTAL = HD + HF + HR + HB;

   // Vertical timing in lines
   localparam int VD     = 1024;
   localparam int VF     = 1;
   localparam int VR     = 3;
   localparam int VB     = 38;
   localparam int VTOTAL = VD + VF + VR + VB;

   // Counters restart at the sync rising edge, so the active window begins
   // after the sync pulse and back porch.
   localparam int HSTART = HR + HB;
   localparam int VSTART = VR + VB;

   // Minimum R+G+B sum that maps to a white pixel
   localparam int THRESH = 23;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_CHECK    = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/vga_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_edge
//  Purpose  : Strobe-qualified sampler and rising-edge detector for one
//             sync signal. The edge is reported in the strobe cycle itself.
//  Revision : 1.0  initial release
// ============================================================================
module vga_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_in,
   output logic rise
);

   logic prev;

   // Remember the level seen at the previous pixel strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= 1'b0;
      end else if (en) begin
         prev <= sync_in;
      end
   end

   assign rise = en & sync_in & ~prev;

endmodule
`default_nettype wire

// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
//  Module   : vga_capture
//  Purpose  : Locks onto an incoming VGA stream, checks line/frame timing,
//             and emits thresholded 1-bit framebuffer writes for active
//             pixels while locked.
//  Revision : 1.0  initial release
// ============================================================================
module vga_capture
   import vga_timing_pkg::*;
#(
   parameter int HD     = vga_timing_pkg::HD,
   parameter int VD     = vga_timing_pkg::VD,
   parameter int HTOTAL = vga_timing_pkg::HTOTAL,
   parameter int VTOTAL = vga_timing_pkg::VTOTAL,
   parameter int HSTART = vga_timing_pkg::HSTART,
   parameter int VSTART = vga_timing_pkg::VSTART,
   parameter int THRESH = vga_timing_pkg::THRESH
) (
   input  logic        clk100mhz_i,
   input  logic        rst_i,
   input  logic        pixel_en_i,
   input  logic        VGA_HS_i,
   input  logic        VGA_VS_i,
   input  logic [11:0] RGB_i,
   input  logic        capture_en_i,
   output logic [10:0] addr_x_o,
   output logic [10:0] addr_y_o,
   output logic        color_o,
   output logic        we_o,
   output logic        locked_o,
   output logic        frame_start_o
);

   localparam logic [10:0] CNT_MAX = 11'h7FF;
   localparam logic [11:0] H_TOTAL = 12'(HTOTAL);
   localparam logic [11:0] V_TOTAL = 12'(VTOTAL);
   localparam logic [10:0] H_FIRST = 11'(HSTART);
   localparam logic [10:0] H_END   = 11'(HSTART + HD);
   localparam logic [10:0] V_FIRST = 11'(VSTART);
   localparam logic [10:0] V_END   = 11'(VSTART + VD);
   localparam logic [5:0]  LUM_MIN = 6'(THRESH);

   logic        hs_rise;
   logic        vs_rise;
   logic [10:0] hcnt;          // position of the most recent strobed pixel
   logic [10:0] vcnt;
   logic        line_err_seen; // a bad line occurred since the last VS edge
   logic        line_err;
   logic        frame_err;
   logic        saturated;
   state_t      state;
   state_t      state_n;
   logic [11:0] rgb_q;
   logic        wr_q;          // strobe qualified by lock and capture enable
   logic        fs_q;
   logic        active;
   logic [5:0]  lum;

   vga_sync_edge u_hs_edge (
      .clk     (clk100mhz_i),
      .rst     (rst_i),
      .en      (pixel_en_i),
      .sync_in (VGA_HS_i),
      .rise    (hs_rise)
   );

   vga_sync_edge u_vs_edge (
      .clk     (clk100mhz_i),
      .rst     (rst_i),
      .en      (pixel_en_i),
      .sync_in (VGA_VS_i),
      .rise    (vs_rise)
   );

   // Checks use the counter values from before the edge reloads them
   assign line_err  = hs_rise && (({1'b0, hcnt} + 12'd1) != H_TOTAL);
   assign frame_err = (({1'b0, vcnt} + 12'd1) != V_TOTAL) || line_err_seen || line_err;
   assign saturated = (hcnt == CNT_MAX) || (vcnt == CNT_MAX);

   // Pixel position counters and per-frame line-error history
   always_ff @(posedge clk100mhz_i) begin
      if (rst_i) begin
         hcnt          <= '0;
         vcnt          <= '0;
         line_err_seen <= 1'b0;
      end else if (pixel_en_i) begin
         if (hs_rise) begin
            hcnt <= '0;
         end else if (hcnt != CNT_MAX) begin
            hcnt <= hcnt + 11'd1;
         end
         // VS edge wins over a coincident HS edge for the line counter
         if (vs_rise) begin
            vcnt <= '0;
         end else if (hs_rise && (vcnt != CNT_MAX)) begin
            vcnt <= vcnt + 11'd1;
         end
         if (vs_rise) begin
            line_err_seen <= 1'b0;
         end else if (line_err) begin
            line_err_seen <= 1'b1;
         end
      end
   end

   // Lock state register and its registered status output
   always_ff @(posedge clk100mhz_i) begin
      if (rst_i) begin
         state    <= ST_UNLOCKED;
         locked_o <= 1'b0;
      end else begin
         state    <= state_n;
         locked_o <= (state_n == ST_LOCKED);
      end
   end

   // Lock acquisition: one VS edge to start measuring, one clean frame to lock
   always_comb begin
      state_n = state;
      case (state)
         ST_UNLOCKED: begin
            if (vs_rise) state_n = ST_CHECK;
         end
         ST_CHECK: begin
            if (vs_rise && !frame_err) state_n = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (line_err || saturated || (vs_rise && frame_err)) state_n = ST_UNLOCKED;
         end
         default: state_n = ST_UNLOCKED;
      endcase
   end

   // First pipeline stage: capture colour and write/frame-start qualifiers
   always_ff @(posedge clk100mhz_i) begin
      if (rst_i) begin
         rgb_q <= '0;
         wr_q  <= 1'b0;
         fs_q  <= 1'b0;
      end else begin
         wr_q <= pixel_en_i && capture_en_i && (state == ST_LOCKED);
         fs_q <= vs_rise && (state_n == ST_LOCKED);
         if (pixel_en_i) rgb_q <= RGB_i;
      end
   end

   assign active = (hcnt >= H_FIRST) && (hcnt < H_END) &&
                   (vcnt >= V_FIRST) && (vcnt < V_END);
   assign lum    = {2'b00, rgb_q[11:8]} + {2'b00, rgb_q[7:4]} + {2'b00, rgb_q[3:0]};

   // Second pipeline stage: framebuffer write; address/colour hold between writes
   always_ff @(posedge clk100mhz_i) begin
      if (rst_i) begin
         we_o          <= 1'b0;
         frame_start_o <= 1'b0;
         addr_x_o      <= '0;
         addr_y_o      <= '0;
         color_o       <= 1'b0;
      end else begin
         we_o          <= wr_q && active;
         frame_start_o <= fs_q;
         if (wr_q && active) begin
            addr_x_o <= hcnt - H_FIRST;
            addr_y_o <= vcnt - V_FIRST;
            color_o  <= (lum >= LUM_MIN);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_capture
//  Purpose  : Scoreboard bench for vga_capture on a reduced 15x8 raster
//             (8x4 active, sync first, HSTART=5, VSTART=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_capture;

   localparam int T_HD     = 8;
   localparam int T_VD     = 4;
   localparam int T_HR     = 2;
   localparam int T_VR     = 1;
   localparam int T_HTOTAL = 15;   // 8 + 2 front + 2 sync + 3 back
   localparam int T_VTOTAL = 8;    // 4 + 1 front + 1 sync + 2 back
   localparam int T_HSTART = 5;
   localparam int T_VSTART = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        pixel_en;
   logic        hs;
   logic        vs;
   logic [11:0] rgb;
   logic        capture_en;
   logic [10:0] addr_x;
   logic [10:0] addr_y;
   logic        color;
   logic        we;
   logic        locked;
   logic        frame_start;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   int n_we   = 0;
   int n_push = 0;
   int exp_x[$];
   int exp_y[$];
   int exp_c[$];
   int exp_t[$];
   int fs_t[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_capture #(
      .HD     (T_HD),
      .VD     (T_VD),
      .HTOTAL (T_HTOTAL),
      .VTOTAL (T_VTOTAL),
      .HSTART (T_HSTART),
      .VSTART (T_VSTART),
      .THRESH (23)
   ) dut (
      .clk100mhz_i   (clk),
      .rst_i         (rst),
      .pixel_en_i    (pixel_en),
      .VGA_HS_i      (hs),
      .VGA_VS_i      (vs),
      .RGB_i         (rgb),
      .capture_en_i  (capture_en),
      .addr_x_o      (addr_x),
      .addr_y_o      (addr_y),
      .color_o       (color),
      .we_o          (we),
      .locked_o      (locked),
      .frame_start_o (frame_start)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Test images; expected colours are worked out by hand:
   // FFF=45 ->1, 000 ->0, 888=24 ->1, 777=21 ->0, F80=23 ->1, 9A0=19 ->0
   function automatic logic [11:0] pat_rgb(input int pat, input int ax, input int ay);
      case (pat)
         0:       return (ax == 5 && ay == 2) ? 12'hFFF : 12'h000;
         1:       return (ax % 2 != 0) ? 12'h888 : 12'h777;
         default: return (ay % 2 != 0) ? 12'hF80 : 12'h9A0;
      endcase
   endfunction

   function automatic int pat_col(input int pat, input int ax, input int ay);
      case (pat)
         0:       return (ax == 5 && ay == 2) ? 1 : 0;
         1:       return (ax % 2 != 0) ? 1 : 0;
         default: return (ay % 2 != 0) ? 1 : 0;
      endcase
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_we"}, we, 0);
      check({tag, "_frame_start"}, frame_start, 0);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_addr_x"}, addr_x, 0);
      check({tag, "_addr_y"}, addr_y, 0);
      check({tag, "_color"}, color, 0);
   endtask

   // One pixel strobe at raster position (gx, gy); optional idle gap cycle
   task automatic send_strobe(input int gx, input int gy, input int pat, input bit wr, input bit gap);
      int ax;
      int ay;
      ax = gx - T_HSTART;
      ay = gy - T_VSTART;
      pixel_en = 1'b1;
      hs       = (gx < T_HR);
      vs       = (gy < T_VR);
      rgb      = pat_rgb(pat, ax, ay);
      if (wr && ax >= 0 && ax < T_HD && ay >= 0 && ay < T_VD) begin
         exp_x.push_back(ax);
         exp_y.push_back(ay);
         exp_c.push_back(pat_col(pat, ax, ay));
         exp_t.push_back(cyc + 2);
         n_push++;
      end
      @(negedge clk);
      if (gap) begin
         // junk on the sync/colour lines must be ignored between strobes
         pixel_en = 1'b0;
         hs       = 1'b1;
         vs       = 1'b1;
         rgb      = 12'hFFF;
         @(negedge clk);
      end
   endtask

   // Rows first_row..last_row-1 of a frame; 'lck' is the lock state expected
   // after this frame's VS edge. short_row gets one strobe less.
   task automatic run_frame(input bit lck, input int pat, input bit gap, input int short_row,
                            input int cap_off_row, input int first_row, input int last_row);
      bit lock_now;
      int len;
      lock_now = lck;
      for (int gy = first_row; gy < last_row; gy++) begin
         len = (gy == short_row) ? T_HTOTAL - 1 : T_HTOTAL;
         for (int gx = 0; gx < len; gx++) begin
            capture_en = !(cap_off_row >= 0 && gy >= cap_off_row);
            if (gx == 0 && gy == 0 && lck) fs_t.push_back(cyc + 2);
            send_strobe(gx, gy, pat, lock_now && capture_en, gap);
            if (gx == 0) begin
               if (short_row >= 0 && gy == short_row + 1) lock_now = 1'b0;
               check("locked_o", locked, lock_now);
            end
         end
      end
      capture_en = 1'b1;
   endtask

   // Scoreboard monitor: pops one expectation per output event
   always @(negedge clk) begin
      if (we === 1'b1) begin
         n_we++;
         if (exp_t.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: write at x=%0d y=%0d cycle %0d, required none", addr_x, addr_y, cyc);
         end else begin
            check("write_cycle", cyc, exp_t.pop_front());
            check("addr_x", addr_x, exp_x.pop_front());
            check("addr_y", addr_y, exp_y.pop_front());
            check("color", color, exp_c.pop_front());
         end
      end
      if (frame_start === 1'b1) begin
         if (fs_t.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_start: pulse at cycle %0d, required none", cyc);
         end else begin
            check("frame_start_cycle", cyc, fs_t.pop_front());
         end
      end
   end

   initial begin
      int base;
      rst        = 1'b1;
      pixel_en   = 1'b0;
      hs         = 1'b0;
      vs         = 1'b0;
      rgb        = 12'h000;
      capture_en = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("in_reset");
      rst = 1'b0;
      @(negedge clk);
      check_zero("after_reset");

      // A: first VS edge starts measurement, B: clean frame closes -> lock
      base = n_we;
      run_frame(1'b0, 0, 1'b0, -1, -1, 0, T_VTOTAL);
      check("writes_frame_a", n_we - base, 0);
      base = n_we;
      run_frame(1'b1, 0, 1'b0, -1, -1, 0, T_VTOTAL);
      check("writes_frame_b", n_we - base, 32);

      // C: strobe every other cycle, same raster
      base = n_we;
      run_frame(1'b1, 1, 1'b1, -1, -1, 0, T_VTOTAL);
      check("writes_frame_c_gap", n_we - base, 32);

      // D: row 4 one strobe short -> unlock at start of row 5
      base = n_we;
      run_frame(1'b1, 2, 1'b0, 4, -1, 0, T_VTOTAL);
      check("writes_frame_d_short", n_we - base, 16);
      base = n_we;
      run_frame(1'b0, 2, 1'b0, -1, -1, 0, T_VTOTAL);
      check("writes_frame_e_relock", n_we - base, 0);

      // F: relocked; capture disabled from row 5 on. G: lock must survive.
      base = n_we;
      run_frame(1'b1, 1, 1'b0, -1, 5, 0, T_VTOTAL);
      check("writes_frame_f_capoff", n_we - base, 16);

      // G: reset in the middle of the frame
      run_frame(1'b1, 2, 1'b0, -1, -1, 0, 5);
      pixel_en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero("mid_reset");
      rst = 1'b0;
      @(negedge clk);
      check_zero("post_mid_reset");
      base = n_we;
      run_frame(1'b0, 2, 1'b0, -1, -1, 5, T_VTOTAL);
      run_frame(1'b0, 2, 1'b0, -1, -1, 0, T_VTOTAL);
      check("writes_after_reset_unlocked", n_we - base, 0);
      base = n_we;
      run_frame(1'b1, 0, 1'b0, -1, -1, 0, T_VTOTAL);
      check("writes_frame_j", n_we - base, 32);

      // Sync lost: hcnt runs up to 2047 and must drop the lock
      for (int k = 0; k < 2100; k++) begin
         pixel_en = 1'b1;
         hs       = 1'b0;
         vs       = 1'b0;
         rgb      = 12'h000;
         @(negedge clk);
         if (k == 1500) check("locked_before_saturation", locked, 1);
      end
      check("locked_after_saturation", locked, 0);

      pixel_en = 1'b0;
      repeat (4) @(negedge clk);
      check("pending_writes", exp_t.size(), 0);
      check("pending_frame_starts", fs_t.size(), 0);
      check("total_writes", n_we, n_push);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
